// File: rtl/tile_map_renderer.sv
// Tile map renderer: walks the map (whole map or one tile), fetches each tile ID,
// streams the tile's sprite pixels and emits screen coordinates, colour and write_en.
module tile_map_renderer #(
  parameter int MAP_COLS       = 11,
  parameter int MAP_ROWS       = 11,
  parameter int TILE_W         = 16,
  parameter int TILE_H         = 16,
  parameter int ORIGIN_X       = 72,
  parameter int ORIGIN_Y       = 32,
  parameter int X_W            = 9,
  parameter int Y_W            = 8,
  parameter int ID_W           = 4,
  parameter int COLOUR_W       = 3,
  parameter int MAP_AW         = 7,
  parameter int ROM_AW         = 12,
  parameter int TRANSPARENT_EN = 0,
  parameter int KEY_COLOUR     = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                single_mode,
  input  logic [7:0]          tile_col,
  input  logic [7:0]          tile_row,
  output logic [MAP_AW-1:0]   map_addr,
  input  logic [ID_W-1:0]     map_data,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      X_out,
  output logic [Y_W-1:0]      Y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                write_en,
  output logic                busy,
  output logic                done
);

  localparam int TILE_PIX = TILE_W * TILE_H;
  localparam int PX_W     = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int PY_W     = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  typedef enum logic [2:0] {
    IDLE,
    MAP_REQ,
    MAP_WAIT,
    DRAW,
    FLUSH,
    DONE
  } state_t;

  state_t                state_reg;
  logic                  single_reg;
  logic [7:0]            col_reg;
  logic [7:0]            row_reg;
  logic [MAP_AW-1:0]     map_addr_reg;
  logic [ID_W-1:0]       id_reg;
  logic [PX_W-1:0]       px_reg;
  logic [PY_W-1:0]       py_reg;
  logic [X_W-1:0]        x_reg;
  logic [Y_W-1:0]        y_reg;
  logic [COLOUR_W-1:0]   colour_hold_reg;
  logic                  pix_valid_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic                  start_in_range;
  logic                  last_px;
  logic                  last_py;
  logic                  last_col;
  logic                  last_row;
  logic                  key_hit;
  logic [MAP_AW-1:0]     single_addr;
  logic [X_W-1:0]        x_pix;
  logic [Y_W-1:0]        y_pix;

  assign start_in_range = (int'(tile_col) < MAP_COLS) && (int'(tile_row) < MAP_ROWS);
  assign single_addr    = MAP_AW'(int'(tile_row) * MAP_COLS + int'(tile_col));
  assign last_px        = (int'(px_reg) == TILE_W - 1);
  assign last_py        = (int'(py_reg) == TILE_H - 1);
  assign last_col       = (int'(col_reg) == MAP_COLS - 1);
  assign last_row       = (int'(row_reg) == MAP_ROWS - 1);

  // The ROM registers its read, so the address is formed straight from the pixel counters.
  assign rom_addr = ROM_AW'(int'(id_reg) * TILE_PIX + int'(py_reg) * TILE_W + int'(px_reg));
  assign x_pix    = X_W'(ORIGIN_X + int'(col_reg) * TILE_W + int'(px_reg));
  assign y_pix    = Y_W'(ORIGIN_Y + int'(row_reg) * TILE_H + int'(py_reg));

  // rom_data arrives in the same cycle as the registered coordinates; the ROM's
  // output register is the colour stage, and the hold register keeps it stable afterwards.
  assign key_hit    = (TRANSPARENT_EN != 0) && (rom_data == COLOUR_W'(KEY_COLOUR));
  assign write_en   = pix_valid_reg && !key_hit;
  assign colour_out = pix_valid_reg ? rom_data : colour_hold_reg;
  assign X_out      = x_reg;
  assign Y_out      = y_reg;
  assign map_addr   = map_addr_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      single_reg      <= 1'b0;
      col_reg         <= '0;
      row_reg         <= '0;
      map_addr_reg    <= '0;
      id_reg          <= '0;
      px_reg          <= '0;
      py_reg          <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      colour_hold_reg <= '0;
      pix_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg      <= 1'b0;
      pix_valid_reg <= (state_reg == DRAW);
      if (state_reg == DRAW) begin
        x_reg <= x_pix;
        y_reg <= y_pix;
      end
      if (pix_valid_reg) begin
        colour_hold_reg <= rom_data;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            single_reg <= single_mode;
            if (single_mode) begin
              col_reg <= tile_col;
              row_reg <= tile_row;
            end else begin
              col_reg <= '0;
              row_reg <= '0;
            end
            if (single_mode && !start_in_range) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              map_addr_reg <= single_mode ? single_addr : '0;
              state_reg    <= MAP_REQ;
              busy_reg     <= 1'b1;
            end
          end
        end

        MAP_REQ: state_reg <= MAP_WAIT;

        MAP_WAIT: begin
          id_reg    <= map_data;
          px_reg    <= '0;
          py_reg    <= '0;
          state_reg <= DRAW;
        end

        DRAW: begin
          if (last_px) begin
            px_reg <= '0;
            if (last_py) begin
              py_reg    <= '0;
              state_reg <= FLUSH;
            end else begin
              py_reg <= py_reg + PY_W'(1);
            end
          end else begin
            px_reg <= px_reg + PX_W'(1);
          end
        end

        FLUSH: begin
          if (single_reg || (last_col && last_row)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            map_addr_reg <= map_addr_reg + MAP_AW'(1);
            state_reg    <= MAP_REQ;
            if (last_col) begin
              col_reg <= '0;
              row_reg <= row_reg + 8'd1;
            end else begin
              col_reg <= col_reg + 8'd1;
            end
          end
        end

        DONE: state_reg <= IDLE;

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tile_map_renderer.md
Name: tile_map_renderer

Overview:
- Parametrised successor to the fixed 11x11 stage tile counter and copy path: walks a tile map, fetches each tile ID from map RAM, streams that tile's pixels from a sprite ROM, and emits absolute pixel coordinates, colour and write_en to the VGA/frame-buffer writer.
- Two modes: full-map redraw, and single-tile redraw for tiles changed by bombs or blocks.
- Optional transparent-colour keying.
- Sits between the game control FSM (start/done handshake) and the frame-buffer write port.

Parameters:
- MAP_COLS, 11, tiles per map row
- MAP_ROWS, 11, tile rows
- TILE_W, 16, tile width in pixels
- TILE_H, 16, tile height in pixels
- ORIGIN_X, 72, screen X of tile (0,0) top-left
- ORIGIN_Y, 32, screen Y of tile (0,0) top-left
- X_W, 9, X coordinate width
- Y_W, 8, Y coordinate width
- ID_W, 4, tile ID width
- COLOUR_W, 3, pixel colour width
- MAP_AW, 7, map address width; must satisfy 2^MAP_AW >= MAP_COLS*MAP_ROWS
- ROM_AW, 12, sprite ROM address width; must satisfy 2^ROM_AW >= 2^ID_W*TILE_W*TILE_H
- TRANSPARENT_EN, 0, 1 enables colour-key suppression
- KEY_COLOUR, 0, colour value suppressed when TRANSPARENT_EN=1

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  request a render; sampled only in IDLE
- single_mode  in  1  0 = full map, 1 = one tile; sampled with start
- tile_col  in  8  column for single mode; sampled with start
- tile_row  in  8  row for single mode; sampled with start
- map_addr  out  MAP_AW  map RAM read address (row*MAP_COLS+col)
- map_data  in  ID_W  tile ID; valid 1 cycle after map_addr is presented
- rom_addr  out  ROM_AW  id*TILE_W*TILE_H + py*TILE_W + px
- rom_data  in  COLOUR_W  pixel colour; valid 1 cycle after rom_addr
- X_out  out  X_W  pixel X
- Y_out  out  Y_W  pixel Y
- colour_out  out  COLOUR_W  pixel colour
- write_en  out  1  pixel valid strobe
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high): every output 0, state IDLE, all counters 0. Reset asserted mid-render aborts on the next edge: no further write_en, no done pulse.
- States: IDLE, MAP_REQ, MAP_WAIT, DRAW, FLUSH, DONE.
- IDLE:
  - start=1 latches the mode and the start column/row (full mode: col=0, row=0).
  - Single mode with tile_col>=MAP_COLS or tile_row>=MAP_ROWS goes to DONE: zero writes, done pulses.
  - Otherwise go to MAP_REQ.
- MAP_REQ: drive map_addr; go to MAP_WAIT.
- MAP_WAIT: latch map_data as tile ID; px=py=0; go to DRAW.
- DRAW:
  - One rom_addr is issued per cycle. px increments; on px=TILE_W-1, px wraps to 0 and py increments.
  - After pixel (TILE_W-1, TILE_H-1) is issued, go to FLUSH.
- Output stage is registered, 1 cycle behind rom_addr:
  - X_out = ORIGIN_X + col*TILE_W + px_d
  - Y_out = ORIGIN_Y + row*TILE_H + py_d
  - Both truncated to X_W and Y_W. colour_out = rom_data.
  - write_en=1 for each issued pixel, except when TRANSPARENT_EN=1 and rom_data==KEY_COLOUR. In that case write_en=0; X/Y/colour still update.
- FLUSH: emits the last pixel. Then:
  - Single mode: go to DONE.
  - Full mode: advance col. At col=MAP_COLS-1, col wraps to 0 and row increments. After the last tile (col=MAP_COLS-1, row=MAP_ROWS-1), go to DONE; otherwise go to MAP_REQ.
- DONE: done=1 and busy=0 for exactly 1 cycle; return to IDLE. start in DONE is ignored.
- start while busy is ignored; latched parameters are unaffected.
- Outside DRAW+1 and FLUSH, write_en=0 and X/Y/colour hold their last values.
- Cycles per tile: TILE_W*TILE_H+3.
- Full render: the start-accept cycle, plus MAP_COLS*MAP_ROWS*(TILE_W*TILE_H+3) busy cycles, then the done cycle.
- Col/row are tracked with counters; no division.

Test Plan:
1. Reset with X/Y/colour pre-loaded to nonzero values → the next edge gives all outputs 0 and state IDLE; start pulsed the same cycle as reset is ignored.
2. MAP_COLS=3, MAP_ROWS=2, TILE_W=TILE_H=2, ORIGIN (72,32), map IDs 0..5, full-mode start → busy for 42 cycles, 24 write_en pulses in raster-per-tile order, first pixel (72,32), last pixel (77,35), done pulses once; rom_addr for tile 5 starts at 20.
3. Default parameters, single mode, col=2, row=1, ID=7 → 256 writes covering X 104..119 and Y 48..63, rom_addr 1792..2047, busy for 259 cycles, then done.
4. TRANSPARENT_EN=1, KEY_COLOUR=0, with a ROM tile that has 0 at pixels (0,0) and (1,1) → write_en is low exactly on those 2 of the 4 pixels, and done still pulses.
5. Single mode with col=11 → no write_en, done 1 cycle after start; start re-asserted during a full render has no effect on the pixel count.
6. Reset asserted at pixel 100 of tile 3 → write_en low from the next edge, no done pulse; a fresh start afterwards renders the full map correctly from (ORIGIN_X, ORIGIN_Y).
